// File: rtl/i2s_tx.sv
// i2s_tx: master-mode I2S transmitter. Generates SCK and WS from aclk and
// shifts stereo PCM frames out on SD, MSB first, Philips alignment (WS leads
// each slot's MSB by one SCK). One-entry holding buffer on the input side.
module i2s_tx #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [2*DATA_W-1:0]   s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic                  SCK,
    output logic                  WS,
    output logic                  SD,
    output logic                  underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRAME = 2 * SLOT_W;
    localparam int B_W   = $clog2(FRAME);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME - 1);
    localparam logic [B_W:0]     L_END    = (B_W+1)'(DATA_W);
    localparam logic [B_W:0]     R_START  = (B_W+1)'(SLOT_W);
    localparam logic [B_W:0]     R_END    = (B_W+1)'(SLOT_W + DATA_W);
    localparam logic [B_W:0]     WS_START = (B_W+1)'(SLOT_W - 1);
    localparam logic [B_W:0]     WS_END   = (B_W+1)'(FRAME - 2);

    logic [DIV_W-1:0]    div_cnt;
    logic [B_W-1:0]      b;
    logic [2*DATA_W-1:0] buf_data;
    logic [2*DATA_W-1:0] shift_reg;
    logic                buf_full;

    logic                tick;
    logic                fall;
    logic                load;
    logic                handshake;
    logic                buf_full_next;
    logic [B_W-1:0]      b_next;
    logic [2*DATA_W-1:0] shift_next;
    logic                sd_next;
    logic                ws_next;

    // True when slot position pos carries a sample bit rather than padding.
    function automatic logic is_data_pos(input logic [B_W-1:0] pos);
        logic [B_W:0] p;
        p = {1'b0, pos};
        return (p < L_END) || ((p >= R_START) && (p < R_END));
    endfunction

    // Next-state logic: divider events, frame position, shifter and buffer flag.
    always_comb begin
        tick          = (div_cnt == DIV_LAST);
        fall          = tick && SCK;
        load          = fall && (b == B_LAST);
        handshake     = s_tvalid && s_tready;
        b_next        = b;
        shift_next    = shift_reg;
        buf_full_next = buf_full;

        if (fall) begin
            b_next = load ? '0 : b + 1'b1;
        end

        // The shifter only advances after a data bit has been on the wire, so
        // padding positions hold the next slot's MSB at the top.
        if (load) begin
            shift_next = buf_full ? buf_data : '0;
        end else if (fall && is_data_pos(b)) begin
            shift_next = {shift_reg[2*DATA_W-2:0], 1'b0};
        end

        sd_next = is_data_pos(b_next) && shift_next[2*DATA_W-1];
        ws_next = ({1'b0, b_next} >= WS_START) && ({1'b0, b_next} <= WS_END);

        if (load && buf_full) begin
            buf_full_next = 1'b0;
        end else if (handshake) begin
            buf_full_next = 1'b1;
        end
    end

    // Bit-clock divider and frame position counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            div_cnt <= '0;
            SCK     <= 1'b0;
            b       <= B_LAST;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                SCK <= !SCK;
            end
            b <= b_next;
        end
    end

    // Input holding buffer; s_tready mirrors the buffer state one edge ahead.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_data <= '0;
            buf_full <= 1'b0;
            s_tready <= 1'b0;
        end else begin
            if (handshake) begin
                buf_data <= s_tdata;
            end
            buf_full <= buf_full_next;
            s_tready <= !buf_full_next;
        end
    end

    // Serial outputs: SD and WS only move on SCK falling events.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shift_reg <= '0;
            SD        <= 1'b0;
            WS        <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            if (fall) begin
                SD <= sd_next;
                WS <= ws_next;
            end
            underrun <= load && !buf_full;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx. A cycle model of the divider and
// frame position predicts SCK/WS/SD/s_tready/underrun every aclk cycle, with
// accepted samples queued until their frame loads. A second instance covers
// the CLK_DIV=1, DATA_W=SLOT_W=16 corner with directed checks.
module tb_i2s_tx;

    localparam int CLK_DIV = 4;
    localparam int DATA_W  = 24;
    localparam int SLOT_W  = 32;
    localparam int FRAME   = 2 * SLOT_W;
    localparam int FCYC    = FRAME * 2 * CLK_DIV;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic [2*DATA_W-1:0] s_tdata;
    logic                s_tvalid;
    logic                s_tready;
    logic                SCK;
    logic                WS;
    logic                SD;
    logic                underrun;

    logic                aresetn2;
    logic [31:0]         s_tdata2;
    logic                s_tvalid2;
    logic                s_tready2;
    logic                sck2;
    logic                ws2;
    logic                sd2;
    logic                underrun2;

    int total = 0;
    int bad   = 0;

    // cycle model state for the main instance
    int                  m_cnt;
    int                  m_fb;
    int                  m_edge;
    logic                m_sck;
    logic                m_hs;
    logic                prev_tready;
    logic [2*DATA_W-1:0] m_cur;
    logic [2*DATA_W-1:0] sb_q[$];
    int                  under_seen = 0;

    always #5 aclk = ~aclk;

    i2s_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .SCK      (SCK),
        .WS       (WS),
        .SD       (SD),
        .underrun (underrun)
    );

    i2s_tx #(.CLK_DIV(1), .DATA_W(16), .SLOT_W(16)) dut_fast (
        .aclk     (aclk),
        .aresetn  (aresetn2),
        .s_tdata  (s_tdata2),
        .s_tvalid (s_tvalid2),
        .s_tready (s_tready2),
        .SCK      (sck2),
        .WS       (ws2),
        .SD       (sd2),
        .underrun (underrun2)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model over the aclk edge that just passed and compare.
    task automatic model_step();
        logic       fall;
        logic       exp_sd;
        logic       exp_ws;
        logic       exp_under;
        logic [5:0] idx;
        m_hs = 1'b0;
        if (!aresetn) begin
            m_cnt       = 0;
            m_fb        = FRAME - 1;
            m_edge      = 0;
            m_sck       = 1'b0;
            m_cur       = '0;
            prev_tready = 1'b0;
            sb_q.delete();
            check_output("rst_sck", 64'(SCK), 64'd0);
            check_output("rst_ws", 64'(WS), 64'd0);
            check_output("rst_sd", 64'(SD), 64'd0);
            check_output("rst_tready", 64'(s_tready), 64'd0);
            check_output("rst_underrun", 64'(underrun), 64'd0);
            return;
        end
        m_edge++;
        fall      = 1'b0;
        exp_under = 1'b0;
        m_cnt++;
        if (m_cnt == CLK_DIV) begin
            m_cnt = 0;
            m_sck = !m_sck;
            fall  = !m_sck;
        end
        if (fall) begin
            m_fb = (m_fb == FRAME - 1) ? 0 : m_fb + 1;
            if (m_fb == 0) begin
                if (sb_q.size() > 0) begin
                    m_cur = sb_q.pop_front();
                end else begin
                    m_cur     = '0;
                    exp_under = 1'b1;
                end
            end
        end
        if (s_tvalid && prev_tready) begin
            sb_q.push_back(s_tdata);
            m_hs = 1'b1;
        end
        exp_sd = 1'b0;
        if (m_fb < SLOT_W) begin
            if (m_fb < DATA_W) begin
                idx    = 6'(2 * DATA_W - 1 - m_fb);
                exp_sd = m_cur[idx];
            end
        end else if (m_fb - SLOT_W < DATA_W) begin
            idx    = 6'(DATA_W - 1 - (m_fb - SLOT_W));
            exp_sd = m_cur[idx];
        end
        exp_ws = (m_fb >= SLOT_W - 1) && (m_fb <= FRAME - 2);
        check_output("sck", 64'(SCK), 64'(m_sck));
        check_output("ws", 64'(WS), 64'(exp_ws));
        check_output("sd", 64'(SD), 64'(exp_sd));
        check_output("underrun", 64'(underrun), 64'(exp_under));
        check_output("tready", 64'(s_tready), 64'(sb_q.size() == 0));
        if (underrun === 1'b1) under_seen++;
        prev_tready = s_tready;
    endtask

    task automatic tick();
        @(negedge aclk);
        model_step();
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (m_edge < target && guard < 4 * FCYC) begin
            tick();
            guard++;
        end
    endtask

    // Present one sample and wait (bounded) for it to be accepted.
    task automatic apply_stimulus(input logic [2*DATA_W-1:0] data, input bit hold_valid);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = data;
        n        = 0;
        tick();
        while (!m_hs && n < 2 * FCYC) begin
            tick();
            n++;
        end
        check_output("accept", 64'(m_hs), 64'd1);
        if (!hold_valid) s_tvalid = 1'b0;
    endtask

    initial begin
        int            u_before;
        int            guard;
        int            f;
        int            bpos;
        logic          e_sd;
        logic          e_ws;
        logic [4:0]    i2;
        logic [31:0]   word2;

        aresetn   = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        aresetn2  = 1'b0;
        s_tvalid2 = 1'b0;
        s_tdata2  = '0;

        $display("[TB] reset and single frame");
        repeat (4) tick();
        aresetn = 1'b1;
        apply_stimulus({24'hABCDEF, 24'h123456}, 1'b0);
        run_until(2 * CLK_DIV + FCYC - 8);
        check_output("no_underrun_frame0", 64'(under_seen), 64'd0);

        $display("[TB] empty stream");
        run_until(2 * CLK_DIV + 3 * FCYC + 100);
        check_output("three_underruns", 64'(under_seen), 64'd3);

        $display("[TB] backpressure");
        apply_stimulus({24'h800001, 24'hFFFFFE}, 1'b1);
        apply_stimulus({24'h13579B, 24'h2468AC}, 1'b1);
        apply_stimulus({24'hFEDCBA, 24'h0F0F0F}, 1'b0);
        run_until(2 * CLK_DIV + 7 * FCYC - 12);
        check_output("no_underrun_backpressure", 64'(under_seen), 64'd3);
        apply_stimulus({24'hFFFFFF, 24'hFFFFFF}, 1'b0);

        $display("[TB] reset mid-frame");
        guard = 0;
        while (!(m_fb == 40 && m_sck == 1'b1) && guard < 2 * FCYC) begin
            tick();
            guard++;
        end
        check_output("reach_b40", 64'(m_fb), 64'd40);
        check_output("pre_rst_sd", 64'(SD), 64'd1);
        check_output("pre_rst_ws", 64'(WS), 64'd1);
        u_before = under_seen;
        aresetn  = 1'b0;
        #1;
        check_output("async_sck", 64'(SCK), 64'd0);
        check_output("async_ws", 64'(WS), 64'd0);
        check_output("async_sd", 64'(SD), 64'd0);
        check_output("async_tready", 64'(s_tready), 64'd0);
        repeat (3) tick();
        aresetn = 1'b1;
        apply_stimulus({24'hC0FFEE, 24'h0BEEF0}, 1'b0);
        run_until(2 * CLK_DIV + FCYC - 8);
        check_output("no_underrun_after_rst", 64'(under_seen), 64'(u_before));
        run_until(2 * CLK_DIV + FCYC + 16);
        check_output("underrun_frame1", 64'(under_seen), 64'(u_before + 1));

        $display("[TB] CLK_DIV=1 DATA_W=SLOT_W=16 corner");
        check_output("fast_rst", 64'({sck2, ws2, sd2, s_tready2, underrun2}), 64'd0);
        word2     = 32'h8001_7FFE;
        aresetn2  = 1'b1;
        s_tvalid2 = 1'b1;
        s_tdata2  = word2;
        for (int e = 1; e <= 132; e++) begin
            tick();
            if (e == 2) s_tvalid2 = 1'b0;
            f    = e / 2;
            e_sd = 1'b0;
            e_ws = 1'b0;
            if (f > 0) begin
                bpos = (f - 1) % 32;
                e_ws = (bpos >= 15) && (bpos <= 30);
                if ((f - 1) / 32 == 1) begin
                    i2   = 5'(31 - bpos);
                    e_sd = word2[i2];
                end
            end
            check_output("fast_sck", 64'(sck2), 64'(e % 2));
            check_output("fast_sd", 64'(sd2), 64'(e_sd));
            check_output("fast_ws", 64'(ws2), 64'(e_ws));
            check_output("fast_underrun", 64'(underrun2), 64'((e == 2) || (e == 130)));
            check_output("fast_tready", 64'(s_tready2), 64'((e == 1) || (e >= 66)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
